// File: rtl/con_eval_unit.sv
// con_eval_unit: two-stage branch-condition evaluator (flag capture, then evaluate/register).
// Define CON_EVAL_HISTORY_EN to build the con_hist / hist_count result history.
module con_eval_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int HIST_DEPTH = 8
) (
   input  logic                            clock,
   input  logic                            clear,
   input  logic                            con_in,
   input  logic [2:0]                      cond_sel,
   input  logic signed [DATA_WIDTH-1:0]    bus_mux_out,
   output logic                            con_out,
   output logic                            con_valid,
   output logic [HIST_DEPTH-1:0]           con_hist,
   output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count
);

   localparam int CNT_W = $clog2(HIST_DEPTH+1);

   function automatic logic eval_cond(input logic [2:0] code, input logic zero, input logic neg);
      case (code)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b010:  return !neg;
         3'b011:  return neg;
         3'b100:  return !neg && !zero;
         3'b101:  return neg || zero;
         3'b110:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   logic [2:0] cond_p1;
   logic       zero_p1;
   logic       neg_p1;
   logic       vld_p1;
   logic       res_p1;

   // Stage 1: capture condition code and operand flags on the strobe
   always_ff @(posedge clock) begin
      if (clear) vld_p1 <= 1'b0;
      else       vld_p1 <= con_in;
   end

   always_ff @(posedge clock) begin
      if (con_in) begin
         cond_p1 <= cond_sel;
         zero_p1 <= (bus_mux_out == '0);
         neg_p1  <= bus_mux_out[DATA_WIDTH-1];
      end
   end

   assign res_p1 = eval_cond(cond_p1, zero_p1, neg_p1);

   // Stage 2: register result; con_out holds between valid pulses
   always_ff @(posedge clock) begin
      if (clear) begin
         con_out   <= 1'b0;
         con_valid <= 1'b0;
      end else begin
         con_valid <= vld_p1;
         if (vld_p1) con_out <= res_p1;
      end
   end

`ifdef CON_EVAL_HISTORY_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      if (cnt == CNT_W'(HIST_DEPTH)) return cnt;
      else                            return cnt + CNT_W'(1);
   endfunction

   logic [HIST_DEPTH-1:0] hist_p2;
   logic [CNT_W-1:0]      cnt_p2;

   // History advances on the same edge that raises con_valid
   always_ff @(posedge clock) begin
      if (clear) begin
         hist_p2 <= '0;
         cnt_p2  <= '0;
      end else if (vld_p1) begin
         hist_p2 <= (hist_p2 << 1) | HIST_DEPTH'(res_p1);
         cnt_p2  <= sat_inc(cnt_p2);
      end
   end

   assign con_hist   = hist_p2;
   assign hist_count = cnt_p2;
`else
   assign con_hist   = '0;
   assign hist_count = '0;
`endif

endmodule

// File: tb/tb_con_eval_unit.sv
// Self-checking bench for con_eval_unit: directed table, history/narrow-width sequences, random vs model.
module tb_con_eval_unit;

`ifdef CON_EVAL_HISTORY_EN
   localparam bit HIST_ON = 1'b1;
`else
   localparam bit HIST_ON = 1'b0;
`endif
   localparam int HD = 4;

   logic        clock = 1'b0;
   logic        clear;
   logic        con_in;
   logic [2:0]  cond_sel;
   logic [31:0] bus_mux_out;
   logic        con_out, con_valid;
   logic [HD-1:0] con_hist;
   logic [2:0]  hist_count;

   logic        con_in8;
   logic [2:0]  cond_sel8;
   logic [7:0]  bus_mux_out8;
   logic        con_out8, con_valid8;
   logic [HD-1:0] con_hist8;
   logic [2:0]  hist_count8;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   con_eval_unit #(.DATA_WIDTH(32), .HIST_DEPTH(HD)) dut (
      .clock(clock), .clear(clear), .con_in(con_in), .cond_sel(cond_sel),
      .bus_mux_out(bus_mux_out), .con_out(con_out), .con_valid(con_valid),
      .con_hist(con_hist), .hist_count(hist_count)
   );

   con_eval_unit #(.DATA_WIDTH(8), .HIST_DEPTH(HD)) dut8 (
      .clock(clock), .clear(clear), .con_in(con_in8), .cond_sel(cond_sel8),
      .bus_mux_out(bus_mux_out8), .con_out(con_out8), .con_valid(con_valid8),
      .con_hist(con_hist8), .hist_count(hist_count8)
   );

   // Reference model state: the pending strobe and the architecturally visible outputs
   bit          m_pend, m_pres, m_out, m_vld;
   bit [HD-1:0] m_hist;
   int          m_cnt;

   function automatic bit ref_eval(input bit [2:0] sel, input logic [31:0] op);
      int signed v;
      v = $signed(op);
      case (sel)
         3'd0: return v == 0;
         3'd1: return v != 0;
         3'd2: return v >= 0;
         3'd3: return v < 0;
         3'd4: return v > 0;
         3'd5: return v <= 0;
         3'd6: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit ci, input bit [2:0] sel, input logic [31:0] op, input bit clr);
      con_in = ci; cond_sel = sel; bus_mux_out = op; clear = clr;
      @(posedge clock);
      if (clr) begin
         m_pend = 0; m_out = 0; m_vld = 0; m_hist = '0; m_cnt = 0;
      end else begin
         m_vld = m_pend;
         if (m_pend) begin
            m_out  = m_pres;
            m_hist = {m_hist[HD-2:0], m_pres};
            if (m_cnt < HD) m_cnt++;
         end
         m_pend = ci;
         m_pres = ref_eval(sel, op);
      end
      #1;
      chk("model_con_out", con_out, m_out);
      chk("model_con_valid", con_valid, m_vld);
      chk("model_con_hist", con_hist, HIST_ON ? m_hist : '0);
      chk("model_hist_count", hist_count, HIST_ON ? m_cnt : 0);
   endtask

   typedef struct {
      bit          clr;
      bit          ci;
      bit [2:0]    sel;
      logic [31:0] op;
      bit          exp_out;
      bit          exp_vld;
   } vec_t;

   vec_t vecs[25];

   initial begin
      bit [2:0]    rsel;
      logic [31:0] rop;
      bit [3:0]    exp_h;
      int          exp_c;

      clear = 1'b1; con_in = 1'b0; cond_sel = '0; bus_mux_out = '0;
      con_in8 = 1'b0; cond_sel8 = '0; bus_mux_out8 = '0;

      vecs = '{
         '{1,0,3'b000,32'h0,       0,0},   // reset state
         '{0,1,3'b000,32'h0,       0,0},   // zero test strobe
         '{0,0,3'b000,32'h5,       1,1},
         '{0,0,3'b000,32'h5,       1,0},
         '{0,1,3'b011,32'hFFFFFFFF,1,0},   // back-to-back four
         '{0,1,3'b010,32'h5,       1,1},
         '{0,1,3'b100,32'h0,       1,1},
         '{0,1,3'b101,32'h0,       0,1},
         '{0,0,3'b000,32'h0,       1,1},
         '{0,0,3'b000,32'h0,       1,0},
         '{0,1,3'b110,32'h1234,    1,0},   // strobe then clear
         '{1,1,3'b110,32'h1234,    0,0},
         '{0,0,3'b110,32'h1234,    0,0},
         '{0,1,3'b110,32'h7B,      0,0},   // constants
         '{0,1,3'b111,32'h0,       1,1},
         '{0,0,3'b110,32'h0,       0,1},
         '{0,0,3'b000,32'h0,       0,0},   // idle operand toggling
         '{0,0,3'b110,32'hFFFF,    0,0},
         '{1,0,3'b000,32'h0,       0,0},
         '{0,1,3'b000,32'h0,       0,0},   // first edge after clear
         '{0,0,3'b000,32'h0,       1,1},
         '{0,1,3'b011,32'h80000000,1,0},   // most-negative operand
         '{0,1,3'b000,32'h80000000,1,1},
         '{0,0,3'b000,32'h0,       0,1},
         '{0,0,3'b000,32'h0,       0,0}
      };

      for (int i = 0; i < 25; i++) begin
         cycle(vecs[i].ci, vecs[i].sel, vecs[i].op, vecs[i].clr);
         chk($sformatf("vec%0d_con_out", i), con_out, vecs[i].exp_out);
         chk($sformatf("vec%0d_con_valid", i), con_valid, vecs[i].exp_vld);
      end

      // History: results 1,0,1,1,0 then clear
      cycle(0, 3'b000, 32'h0, 1);
      cycle(1, 3'b110, 32'h0, 0);
      cycle(1, 3'b111, 32'h0, 0);
      cycle(1, 3'b110, 32'h0, 0);
      cycle(1, 3'b110, 32'h0, 0);
      cycle(1, 3'b111, 32'h0, 0);
      cycle(0, 3'b000, 32'h0, 0);
      exp_h = HIST_ON ? 4'b0110 : 4'b0000;
      exp_c = HIST_ON ? 4 : 0;
      chk("hist_after_five", con_hist, exp_h);
      chk("hist_count_saturated", hist_count, exp_c);
      cycle(0, 3'b000, 32'h0, 1);
      chk("hist_cleared", con_hist, 0);
      chk("hist_count_cleared", hist_count, 0);

      // 8-bit instance: 0x80 is negative, 0x7F is positive non-zero
      con_in8 = 1'b1; cond_sel8 = 3'b011; bus_mux_out8 = 8'h80;
      cycle(0, 3'b000, 32'h0, 0);
      con_in8 = 1'b1; cond_sel8 = 3'b100; bus_mux_out8 = 8'h7F;
      cycle(0, 3'b000, 32'h0, 0);
      chk("w8_neg_out", con_out8, 1);
      chk("w8_neg_valid", con_valid8, 1);
      con_in8 = 1'b1; cond_sel8 = 3'b000; bus_mux_out8 = 8'h80;
      cycle(0, 3'b000, 32'h0, 0);
      chk("w8_pos_out", con_out8, 1);
      chk("w8_pos_valid", con_valid8, 1);
      con_in8 = 1'b0;
      cycle(0, 3'b000, 32'h0, 0);
      chk("w8_minneg_zero_out", con_out8, 0);
      chk("w8_minneg_zero_valid", con_valid8, 1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         rsel = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: rop = 32'h0;
            1: rop = 32'h80000000;
            2: rop = 32'hFFFFFFFF;
            default: rop = $urandom;
         endcase
         cycle(bit'($urandom_range(0, 2) != 0), rsel, rop, bit'($urandom_range(0, 24) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
